adc_to_bcd_voltage: RTL and testbench
=====================================

ADC_TO_BCD_VOLTAGE -- requirements
Module: adc_to_bcd_voltage

Interface
REQ-001 SHALL have parameter ADC_W, default 8; ADC sample width.
REQ-002 SHALL have parameter VREF_CV, default 330; full-scale reference in centivolts, legal range 1..4095.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample  input  ADC_W  raw ADC code.
REQ-006 SHALL have port sample_valid  input  1  sample is presented this cycle.
REQ-007 SHALL have port sample_ready  output  1  block is able to accept a sample.
REQ-008 SHALL have port integer_data  output  4  BCD volts digit, X in X.YZ.
REQ-009 SHALL have port float1_data  output  4  BCD tenths digit.
REQ-010 SHALL have port float2_data  output  4  BCD hundredths digit.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse when the digits update.
REQ-012 SHALL have port overrange  output  1  last result was clamped to 9.99.

Function
REQ-013 SHALL implement the FSM IDLE -> SCALE -> CONVERT -> LOAD -> IDLE.
REQ-014 SHALL drive sample_ready = (state == IDLE), decoded directly from the state register.
REQ-015 SHALL accept a sample only on an edge where sample_valid && sample_ready; the accepted sample is registered and the FSM goes IDLE -> SCALE.
REQ-016 SHALL ignore sample_valid outside IDLE: no latching, no queuing.
REQ-017 SCALE (1 cycle) SHALL compute cv = (sample * VREF_CV) >> ADC_W, truncating, into a 12-bit register.
REQ-018 SHALL clamp cv above 999 to 999 and record the clamp as a pending overrange flag; otherwise the pending flag is 0.
REQ-019 CONVERT SHALL run 10 sequential double-dabble iterations, one per cycle, over the 10-bit value and a 12-bit BCD accumulator: add 3 to every nibble >= 5, then shift left 1.
REQ-020 SHALL count iterations with a 4-bit counter: cleared on entry to CONVERT, and the FSM leaves CONVERT after the 10th iteration.
REQ-021 LOAD SHALL write the three nibbles to integer_data, float1_data and float2_data, write pending overrange to overrange, assert data_valid for exactly one cycle, and return to IDLE.
REQ-022 Latency: for acceptance on edge T, the digits and data_valid SHALL update on edge T+12; the earliest next acceptance is edge T+13.
REQ-023 The digit outputs and overrange SHALL hold their values between LOAD events; they are never driven with intermediate results.
REQ-024 data_valid SHALL be 0 in every cycle except the one following a LOAD edge.

Reset
REQ-025 While rst_n is low, the block SHALL force state to IDLE, all digits to 0, data_valid to 0, overrange to 0, and clear the iteration counter and the working registers.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no data_valid pulse; sample_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the state enum, the BCD digit width (4), the clamp constant (999) and the iteration count (10).
REQ-028 The double-dabble datapath SHALL be a sub-module bin2bcd_seq (start, 10-bit binary in, 12-bit BCD out, done), instantiated once; scaling and the FSM stay in the top level.

Verification
REQ-029 Scenario: reset, then sample=0x80 accepted on edge T -> data_valid on edge T+12 with digits 1,6,5 and overrange=0.
REQ-030 Scenario: sample=0xFF -> digits 3,2,8; sample=0x00 -> digits 0,0,0; each gives exactly one data_valid pulse.
REQ-031 Scenario: VREF_CV=1200, sample=0xFF (cv=1195) -> digits 9,9,9 and overrange=1; the following sample=0x10 -> digits 0,7,5 and overrange=0.
REQ-032 Scenario: hold sample_valid high continuously with the value changing every cycle -> one acceptance every 13 cycles; each result matches the value sampled at its acceptance edge.
REQ-033 Scenario: pulse rst_n low at edge T+6 of a conversion -> no data_valid pulse, digits read 0,0,0, and sample_ready=1 after release.

Source files
------------

// File: rtl/adc_to_bcd_voltage_pkg.sv
// Shared definitions for the ADC-code to BCD-voltage converter.
//   state_e    : top-level sequencing states
//   BCD_W      : width of one BCD digit
//   BIN_W      : width of the clamped centivolt value fed to the converter
//   BCD_ACC_W  : width of the three-digit BCD accumulator
//   CLAMP_CV   : largest displayable value (9.99 V in centivolts)
//   DD_ITER    : double-dabble iterations, one per binary input bit
package adc_to_bcd_voltage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCALE   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_LOAD    = 2'd3
  } state_e;

  localparam int          BCD_W     = 4;
  localparam int          BIN_W     = 10;
  localparam int          BCD_ACC_W = 3 * BCD_W;
  localparam logic [11:0] CLAMP_CV  = 12'd999;
  localparam logic [3:0]  DD_ITER   = 4'd10;

endpackage

// File: rtl/adc_to_bcd_voltage_bin2bcd_seq.sv
// Sequential double-dabble converter: 10-bit binary to three BCD digits,
// one add-3/shift iteration per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : first iteration happens on this edge, using bin_in
//   bin_in     : binary value, sampled only on the start edge
//   bcd_out    : BCD accumulator, final once the last iteration has run
//   done       : high in the cycle whose closing edge runs the last iteration
module bin2bcd_seq
  import adc_to_bcd_voltage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin_in,
  output logic [BCD_ACC_W-1:0] bcd_out,
  output logic                 done
);

  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [BCD_ACC_W-1:0] bcd_q, bcd_d;
  logic [3:0]           cnt_q, cnt_d;   // iterations still to run

  logic [BIN_W-1:0]     src_bin;
  logic [BCD_ACC_W-1:0] src_bcd;
  logic [BCD_ACC_W-1:0] adj;

  always_comb begin
    src_bin = bin_q;
    src_bcd = bcd_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = '0;

    // On start the accumulator begins from zero so the first iteration is
    // folded into the load edge rather than costing an extra cycle.
    if (start) begin
      src_bin = bin_in;
      src_bcd = '0;
    end

    for (int i = 0; i < 3; i++) begin
      adj[i*BCD_W +: BCD_W] = (src_bcd[i*BCD_W +: BCD_W] >= 4'd5)
                            ? src_bcd[i*BCD_W +: BCD_W] + 4'd3
                            : src_bcd[i*BCD_W +: BCD_W];
    end

    if (start || (cnt_q != 4'd0)) begin
      bcd_d = {adj[BCD_ACC_W-2:0], src_bin[BIN_W-1]};
      bin_d = {src_bin[BIN_W-2:0], 1'b0};
      cnt_d = start ? (DD_ITER - 4'd1) : (cnt_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_out = bcd_q;
  assign done    = (cnt_q == 4'd1);

endmodule

// File: rtl/adc_to_bcd_voltage.sv
// Converts a raw ADC code to a three-digit BCD voltage X.YZ.
//   clk, rst_n      : clock, async active-low reset
//   sample          : raw ADC code (ADC_W bits)
//   sample_valid    : sample presented this cycle
//   sample_ready    : block is idle and will accept a sample
//   integer_data    : volts digit
//   float1_data     : tenths digit
//   float2_data     : hundredths digit
//   data_valid      : one-cycle pulse when the digits update
//   overrange       : last result was clamped to 9.99
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for sample_valid; sample_ready high
// ST_SCALE   | cv = (sample * VREF_CV) >> ADC_W into cv_q; kick converter
// ST_CONVERT | double-dabble running, one iteration per cycle
// ST_LOAD    | copy digits and overrange to outputs, pulse data_valid
module adc_to_bcd_voltage
  import adc_to_bcd_voltage_pkg::*;
#(
  parameter int ADC_W   = 8,
  parameter int VREF_CV = 330
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic [3:0]       integer_data,
  output logic [3:0]       float1_data,
  output logic [3:0]       float2_data,
  output logic             data_valid,
  output logic             overrange
);

  localparam int PW = ADC_W + 12;

  state_e           state_q, state_d;
  logic [ADC_W-1:0] sample_q, sample_d;
  logic [11:0]      cv_q, cv_d;
  logic             start_q, start_d;
  logic [3:0]       int_q, int_d;
  logic [3:0]       f1_q, f1_d;
  logic [3:0]       f2_q, f2_d;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;

  logic                 ovr_pend;
  logic [BIN_W-1:0]     bin_w;
  logic [BCD_ACC_W-1:0] bcd_w;
  logic                 conv_done;

  // cv_q keeps the unclamped 12-bit product; the clamp and the pending
  // overrange flag are derived from it and stay stable until the next sample.
  assign ovr_pend = (cv_q > CLAMP_CV);
  assign bin_w    = ovr_pend ? CLAMP_CV[BIN_W-1:0] : cv_q[BIN_W-1:0];

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_q),
    .bin_in  (bin_w),
    .bcd_out (bcd_w),
    .done    (conv_done)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cv_d     = cv_q;
    start_d  = 1'b0;
    int_d    = int_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    dv_d     = 1'b0;
    ovr_d    = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          sample_d = sample;
          state_d  = ST_SCALE;
        end
      end
      ST_SCALE: begin
        cv_d    = 12'((PW'(sample_q) * PW'(VREF_CV)) >> ADC_W);
        start_d = 1'b1;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_done) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        int_d   = bcd_w[11:8];
        f1_d    = bcd_w[7:4];
        f2_d    = bcd_w[3:0];
        ovr_d   = ovr_pend;
        dv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      cv_q     <= '0;
      start_q  <= 1'b0;
      int_q    <= '0;
      f1_q     <= '0;
      f2_q     <= '0;
      dv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cv_q     <= cv_d;
      start_q  <= start_d;
      int_q    <= int_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      dv_q     <= dv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_ready = (state_q == ST_IDLE);
  assign integer_data = int_q;
  assign float1_data  = f1_q;
  assign float2_data  = f2_q;
  assign data_valid   = dv_q;
  assign overrange    = ovr_q;

endmodule

// File: tb/tb_adc_to_bcd_voltage.sv
// Directed bench: instance a uses the default 3.30 V reference, instance b
// a 12.00 V reference so the clamp path can be reached.
module tb_adc_to_bcd_voltage;

  logic       clk;
  logic       rst_n;
  logic [7:0] smp_a, smp_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic [3:0] int_a, f1_a, f2_a, int_b, f1_b, f2_b;
  logic       dv_a, dv_b, ovr_a, ovr_b;

  int n_vec  = 0;
  int n_miss = 0;

  adc_to_bcd_voltage dut_a (
    .clk(clk), .rst_n(rst_n), .sample(smp_a), .sample_valid(vld_a),
    .sample_ready(rdy_a), .integer_data(int_a), .float1_data(f1_a),
    .float2_data(f2_a), .data_valid(dv_a), .overrange(ovr_a)
  );

  adc_to_bcd_voltage #(.ADC_W(8), .VREF_CV(1200)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample(smp_b), .sample_valid(vld_b),
    .sample_ready(rdy_b), .integer_data(int_b), .float1_data(f1_b),
    .float2_data(f2_b), .data_valid(dv_b), .overrange(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dig(input bit sel);
    return sel ? {int_b, f1_b, f2_b} : {int_a, f1_a, f2_a};
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction

  function automatic logic dvv(input bit sel);
    return sel ? dv_b : dv_a;
  endfunction

  function automatic logic ovr(input bit sel);
    return sel ? ovr_b : ovr_a;
  endfunction

  // Reference for the streaming run: decimal digits of the clamped centivolts.
  function automatic logic [11:0] model_330(input logic [7:0] s);
    int cv;
    cv = (int'(s) * 330) / 256;
    if (cv > 999) cv = 999;
    return {4'(cv / 100), 4'((cv / 10) % 10), 4'(cv % 10)};
  endfunction

  task automatic conv(input bit sel, input logic [7:0] s, input logic [11:0] exp_dig,
                      input logic exp_ovr, input string tag);
    logic [11:0] prev;
    logic [11:0] got;
    logic        gov;
    int          first;
    int          npulse;
    @(negedge clk);
    prev = dig(sel);
    chk({tag, "_ready_idle"}, 32'(rdy(sel)), 32'd1);
    if (sel) begin smp_b = s; vld_b = 1'b1; end
    else     begin smp_a = s; vld_a = 1'b1; end
    @(posedge clk);
    #1;
    vld_a = 1'b0;
    vld_b = 1'b0;
    first = 0; npulse = 0; got = '0; gov = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 11) begin
        chk({tag, "_hold_before_load"}, 32'(dig(sel)), 32'(prev));
        chk({tag, "_ready_busy"}, 32'(rdy(sel)), 32'd0);
      end
      if (c == 12) chk({tag, "_ready_after"}, 32'(rdy(sel)), 32'd1);
      if (dvv(sel)) begin
        npulse++;
        if (first == 0) begin
          first = c;
          got   = dig(sel);
          gov   = ovr(sel);
        end
      end
    end
    chk({tag, "_latency"}, 32'(first), 32'd12);
    chk({tag, "_pulses"}, 32'(npulse), 32'd1);
    chk({tag, "_digits"}, 32'(got), 32'(exp_dig));
    chk({tag, "_overrange"}, 32'(gov), 32'(exp_ovr));
    chk({tag, "_digits_held"}, 32'(dig(sel)), 32'(exp_dig));
  endtask

  initial begin
    logic [7:0] acc_q[$];
    int         acc_c[$];
    logic [7:0] s;
    int         ac;
    int         nacc;
    int         nres;
    int         ndv;
    logic       rb;

    rst_n = 1'b0;
    smp_a = '0; smp_b = '0;
    vld_a = 1'b0; vld_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_digits", 32'(dig(0)), 32'h000);
    chk("rst_valid", 32'(dv_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_overrange", 32'(ovr_a), 32'd0);

    conv(0, 8'h80, 12'h165, 1'b0, "s80");
    conv(0, 8'hFF, 12'h328, 1'b0, "sFF");
    conv(0, 8'h00, 12'h000, 1'b0, "s00");
    conv(1, 8'hFF, 12'h999, 1'b1, "b_sFF_clamp");
    conv(1, 8'h10, 12'h075, 1'b0, "b_s10");

    // Continuous sample_valid with a new value every cycle.
    nacc = 0; nres = 0;
    for (int cyc = 0; cyc < 52; cyc++) begin
      @(negedge clk);
      smp_a = 8'(cyc * 37 + 5);
      vld_a = 1'b1;
      rb    = rdy_a;
      @(posedge clk);
      #1;
      if (rb) begin
        acc_q.push_back(smp_a);
        acc_c.push_back(cyc);
        nacc++;
      end
      if (dv_a) begin
        if (acc_q.size() == 0) begin
          chk("stream_spurious_valid", 32'd1, 32'd0);
        end else begin
          s  = acc_q.pop_front();
          ac = acc_c.pop_front();
          nres++;
          chk("stream_latency", 32'(cyc - ac), 32'd12);
          chk("stream_digits", 32'(dig(0)), 32'(model_330(s)));
        end
      end
    end
    @(negedge clk);
    vld_a = 1'b0;
    chk("stream_accepts", 32'(nacc), 32'd4);
    chk("stream_results", 32'(nres), 32'd4);
    repeat (15) @(posedge clk);

    // Reset in the middle of a conversion on b (which currently shows 9.99).
    conv(1, 8'hFF, 12'h999, 1'b1, "b_pre_reset");
    @(negedge clk);
    smp_b = 8'h40;
    vld_b = 1'b1;
    @(posedge clk);
    #1;
    vld_b = 1'b0;
    ndv = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (dv_b) ndv++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_async_digits", 32'(dig(1)), 32'h000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready_release", 32'(rdy_b), 32'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (dv_b) ndv++;
    end
    chk("reset_no_valid", 32'(ndv), 32'd0);
    chk("reset_digits", 32'(dig(1)), 32'h000);
    chk("reset_overrange", 32'(ovr_b), 32'd0);
    chk("reset_ready", 32'(rdy_b), 32'd1);

    conv(1, 8'h10, 12'h075, 1'b0, "b_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
